// File: rtl/mux_l1_arb_if.sv
// Lane bundle for the layer-1 transmit mux: four input lanes in, two arbitrated output lanes out.
interface mux_l1_arb_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] Entrada0, Entrada1, Entrada2, Entrada3;
  logic             validEntrada0, validEntrada1, validEntrada2, validEntrada3;
  logic             full0, full1, full2, full3;
  logic [WIDTH-1:0] Salida0, Salida1;
  logic             validSalida0, validSalida1;
  logic             selector0, selector1;
  logic [3:0]       error_ovf;

  modport master (
    output Entrada0, Entrada1, Entrada2, Entrada3,
    output validEntrada0, validEntrada1, validEntrada2, validEntrada3,
    input  full0, full1, full2, full3,
    input  Salida0, Salida1, validSalida0, validSalida1, selector0, selector1,
    input  error_ovf
  );

  modport slave (
    input  Entrada0, Entrada1, Entrada2, Entrada3,
    input  validEntrada0, validEntrada1, validEntrada2, validEntrada3,
    output full0, full1, full2, full3,
    output Salida0, Salida1, validSalida0, validSalida1, selector0, selector1,
    output error_ovf
  );
endinterface

// File: rtl/mux_l1_arb.sv
// Layer-1 mux: four lane FIFOs, two round-robin arbiters (lanes 0/1 -> out 0, lanes 2/3 -> out 1).
// Define MUX_L1_OVF_EN to build the sticky per-lane overflow flags on error_ovf.
module mux_l1_arb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  mux_l1_arb_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0][WIDTH-1:0] din, head;
  logic [3:0]            vin, push, pop, ne, full;
  logic [1:0][WIDTH-1:0] dout;
  logic [1:0]            vout, sout;

  assign din = {bus.Entrada3, bus.Entrada2, bus.Entrada1, bus.Entrada0};
  assign vin = {bus.validEntrada3, bus.validEntrada2, bus.validEntrada1, bus.validEntrada0};

  genvar n, p;
  for (n = 0; n < 4; n++) begin : g_lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    cnt;

    assign ne[n]   = cnt != '0;
    assign full[n] = cnt == CW'(DEPTH);
    // A full FIFO still accepts a word when it is being drained on the same edge.
    assign push[n] = vin[n] && (!full[n] || pop[n]);
    assign head[n] = mem[rptr];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push[n]) wptr <= wptr + AW'(1);
        if (pop[n])  rptr <= rptr + AW'(1);
        if (push[n] && !pop[n])      cnt <= cnt + CW'(1);
        else if (pop[n] && !push[n]) cnt <= cnt - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push[n]) mem[wptr] <= din[n];
    end
  end

  for (p = 0; p < 2; p++) begin : g_pair
    logic             sel, any, both, last;
    logic [WIDTH-1:0] dq;
    logic             vq, sq;

    assign both = ne[2*p] && ne[2*p+1];
    assign any  = ne[2*p] || ne[2*p+1];
    // last-served only matters on contention; a lone lane is served without toggling it.
    assign sel  = both ? ~last : ne[2*p+1];
    assign pop[2*p]   = any && !sel;
    assign pop[2*p+1] = any && sel;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dq   <= '0;
        vq   <= 1'b0;
        sq   <= 1'b0;
        last <= 1'b1;
      end else begin
        vq <= any;
        if (any) begin
          dq <= sel ? head[2*p+1] : head[2*p];
          sq <= sel;
        end
        if (both) last <= ~last;
      end
    end

    assign dout[p] = dq;
    assign vout[p] = vq;
    assign sout[p] = sq;
  end

  assign bus.full0 = full[0];
  assign bus.full1 = full[1];
  assign bus.full2 = full[2];
  assign bus.full3 = full[3];
  assign bus.Salida0      = dout[0];
  assign bus.Salida1      = dout[1];
  assign bus.validSalida0 = vout[0];
  assign bus.validSalida1 = vout[1];
  assign bus.selector0    = sout[0];
  assign bus.selector1    = sout[1];

`ifdef MUX_L1_OVF_EN
  logic [3:0] ovf;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf <= '0;
    else        ovf <= ovf | (vin & ~push);
  end
  assign bus.error_ovf = ovf;
`else
  assign bus.error_ovf = 4'b0000;
`endif
endmodule
